// File: rtl/fifo_rd_arbiter.sv
// Round-robin read arbiter: grants one of four requesters a burst of up to
// BURST pops from a FIFO and forwards each word through an output register.
module fifo_rd_arbiter #(
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    output logic [1:0]       out_id,
    input  logic             out_ready
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [DSIZE-1:0] out_data_q, out_data_d;
    logic [1:0]       out_id_q, out_id_d;

    logic [1:0]       win;
    logic             burst_done;

    // last_q doubles as the current owner while in S_BURST
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= S_IDLE;
            gnt_q       <= 4'b0000;
            last_q      <= 2'd3;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    always_comb begin
        win = last_q;
        for (int i = 4; i >= 1; i--) begin
            if (req[2'(last_q + 2'(i))]) win = 2'(last_q + 2'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|req) state_d = S_BURST;
            S_BURST: if (!req[last_q] || burst_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rinc = (state_q == S_BURST) && !rempty && (!out_valid_q || out_ready)
               && req[last_q] && !rrst;
        burst_done = rinc && (cnt_q == 4'(BURST - 1));

        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;

        if (state_q == S_IDLE) begin
            if (|req) begin
                gnt_d  = 4'b0001 << win;
                last_d = win;
                cnt_d  = 4'd0;
            end
        end else if (state_d == S_IDLE) begin
            gnt_d = 4'b0000;
            cnt_d = 4'd0;
        end else if (rinc) begin
            cnt_d = cnt_q + 4'd1;
        end

        if (rinc) begin
            out_valid_d = 1'b1;
            out_data_d  = rdata;
            out_id_d    = last_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter; a tiny FIFO model supplies rdata = 0x10 + pops.
module tb_fifo_rd_arbiter;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_id;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;
    logic [7:0] ptr;

    fifo_rd_arbiter #(.DSIZE(8), .BURST(4)) dut (
        .rclk(rclk), .rrst(rrst), .req(req), .gnt(gnt), .rempty(rempty),
        .rdata(rdata), .rinc(rinc), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .out_ready(out_ready)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (rrst) ptr <= 8'd0;
        else if (rinc && !rempty) ptr <= ptr + 8'd1;
    end
    assign rdata = 8'h10 + ptr;

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset;
        rrst = 1'b1; req = 4'b0000; rempty = 1'b0; out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset;
        rrst = 1'b1; req = 4'b1111; rempty = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        #2;
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 8'h00 || out_id !== 2'd0) begin
            failures++; $display("FAIL reset_out got=%h/%0d exp=00/0", out_data, out_id);
        end
        checks++;
        if (rinc !== 1'b0) begin failures++; $display("FAIL reset_rinc got=%b exp=0", rinc); end
    endtask

    task automatic test_basic;
        logic [3:0] eg [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        logic       er [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       ev [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            rrst = 1'b0; req = 4'b0001;
            #2;
            checks++;
            if (gnt !== eg[c]) begin failures++; $display("FAIL basic_gnt c=%0d got=%b exp=%b", c, gnt, eg[c]); end
            checks++;
            if (rinc !== er[c]) begin failures++; $display("FAIL basic_rinc c=%0d got=%b exp=%b", c, rinc, er[c]); end
            checks++;
            if (out_valid !== ev[c]) begin failures++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, out_valid, ev[c]); end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (out_data !== 8'(8'h10 + c - 2) || out_id !== 2'd0) begin
                    failures++;
                    $display("FAIL basic_data c=%0d got=%h/%0d exp=%h/0", c, out_data, out_id, 8'(8'h10 + c - 2));
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            rrst = 1'b0; req = 4'b1111;
            exp_g = (c % 5 == 0) ? 4'b0000 : 4'(4'b0001 << ((c / 5) % 4));
            #2;
            checks++;
            if (gnt !== exp_g) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, exp_g); end
            checks++;
            if (rinc !== (exp_g != 4'b0000)) begin
                failures++; $display("FAIL rr_rinc c=%0d got=%b exp=%b", c, rinc, exp_g != 4'b0000);
            end
            tick();
        end
    endtask

    task automatic test_stall;
        logic [3:0] exp_g;
        logic       exp_r;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            rrst = 1'b0; req = 4'b0100;
            rempty = (c >= 3 && c <= 7);
            exp_g = (c >= 1 && c <= 9) ? 4'b0100 : 4'b0000;
            exp_r = (c == 1 || c == 2 || c == 8 || c == 9);
            #2;
            checks++;
            if (gnt !== exp_g) begin failures++; $display("FAIL stall_gnt c=%0d got=%b exp=%b", c, gnt, exp_g); end
            checks++;
            if (rinc !== exp_r) begin failures++; $display("FAIL stall_rinc c=%0d got=%b exp=%b", c, rinc, exp_r); end
            if (c == 10) begin
                checks++;
                if (out_data !== 8'h13 || out_id !== 2'd2) begin
                    failures++; $display("FAIL stall_last got=%h/%0d exp=13/2", out_data, out_id);
                end
            end
            tick();
        end
        rempty = 1'b0;
    endtask

    task automatic test_backpressure;
        logic exp_r;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            rrst = 1'b0; req = 4'b0001;
            out_ready = !(c >= 2 && c <= 4);
            exp_r = (c == 1 || c == 5 || c == 6);
            #2;
            checks++;
            if (rinc !== exp_r) begin failures++; $display("FAIL bp_rinc c=%0d got=%b exp=%b", c, rinc, exp_r); end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'h10) begin
                    failures++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/10", c, out_valid, out_data);
                end
            end
            if (c == 6) begin
                checks++;
                if (out_data !== 8'h11) begin failures++; $display("FAIL bp_next got=%h exp=11", out_data); end
            end
            tick();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_release;
        logic [3:0] exp_g;
        logic       exp_r;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            rrst = 1'b0;
            req = (c < 2) ? 4'b0010 : 4'b0100;
            exp_g = (c == 1 || c == 2) ? 4'b0010 : (c >= 4 && c <= 7) ? 4'b0100 : 4'b0000;
            exp_r = (c == 1) || (c >= 4 && c <= 7);
            #2;
            checks++;
            if (gnt !== exp_g) begin failures++; $display("FAIL rel_gnt c=%0d got=%b exp=%b", c, gnt, exp_g); end
            checks++;
            if (rinc !== exp_r) begin failures++; $display("FAIL rel_rinc c=%0d got=%b exp=%b", c, rinc, exp_r); end
            tick();
        end
    endtask

    task automatic test_midburst_reset;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            rrst = 1'b0; req = 4'b0001;
            tick();
        end
        rrst = 1'b1;
        #2;
        checks++;
        if (rinc !== 1'b0 || out_valid !== 1'b1 || gnt !== 4'b0001) begin
            failures++; $display("FAIL mrst_during got=%b/%b/%b exp=0/1/0001", rinc, out_valid, gnt);
        end
        tick();
        rrst = 1'b0; req = 4'b1000;
        #2;
        checks++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0 || rinc !== 1'b0) begin
            failures++; $display("FAIL mrst_after got=%b/%b/%b exp=0000/0/0", gnt, out_valid, rinc);
        end
        tick();
        #2;
        checks++;
        if (gnt !== 4'b1000) begin failures++; $display("FAIL mrst_regrant got=%b exp=1000", gnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_backpressure();
        test_release();
        test_midburst_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 The block SHALL take parameter DSIZE, default 8, as the read-data width in bits, matching the FIFO data width.
REQ-002 The block SHALL take parameter BURST, default 4, as the maximum words popped per grant (range 1..15).
REQ-003 The block SHALL have port rclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rrst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, 4 bits: per-requester read request, level-sensitive.
REQ-006 The block SHALL have port gnt, output, 4 bits: registered one-hot grant, all-zero when no owner.
REQ-007 The block SHALL have port rempty, input, 1 bit: FIFO read-side empty flag.
REQ-008 The block SHALL have port rdata, input, DSIZE bits: FIFO data at the current read address, valid whenever rempty=0.
REQ-009 The block SHALL have port rinc, output, 1 bit: FIFO pop strobe, combinational.
REQ-010 The block SHALL have port out_valid, output, 1 bit: output register holds a word.
REQ-011 The block SHALL have port out_data, output, DSIZE bits: popped word.
REQ-012 The block SHALL have port out_id, output, 2 bits: index of the requester that owned the pop.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data when out_valid=1.

Function
REQ-014 The FSM SHALL have two states: IDLE (no owner, gnt=0) and BURST (one owner, gnt one-hot).
REQ-015 In IDLE with req!=0, the block SHALL select a winner round-robin, searching from (last+1) mod 4 upward, and SHALL enter BURST with gnt set on the next edge; request-to-grant latency is 1 cycle.
REQ-016 In IDLE with req=0, the block SHALL stay in IDLE.
REQ-017 The block SHALL update last to the winner index at grant time.
REQ-018 The block SHALL assert rinc = (state==BURST) & ~rempty & (~out_valid | out_ready) & req[owner].
REQ-019 On each rinc cycle, the block SHALL load out_data<=rdata and out_id<=owner, and SHALL set out_valid=1 on the next edge.
REQ-020 The block SHALL clear out_valid when out_valid & out_ready and no rinc occurs in the same cycle; simultaneous accept and pop SHALL keep out_valid=1 with the new word (full throughput, 1 word per cycle).
REQ-021 The block SHALL use a 4-bit burst counter, cleared on grant and incremented on each rinc.
REQ-022 The block SHALL return to IDLE, clearing gnt on the next edge, when rinc occurs with count==BURST-1 (burst complete).
REQ-023 The block SHALL return to IDLE when req[owner]=0 in BURST (voluntary release); no pop occurs in that cycle.
REQ-024 rempty=1 in BURST SHALL stall without releasing; the grant is held while req[owner]=1 until BURST words have been popped.
REQ-025 After any release the block SHALL spend at least one cycle in IDLE before the next grant.
REQ-026 The block SHALL never assert rinc while rempty=1 or while state==IDLE.
REQ-027 req changes of non-owners SHALL have no effect during BURST.

Reset
REQ-028 While rrst=1 on a clock edge, the block SHALL set: state=IDLE, gnt=0, last=3 (requester 0 wins first), count=0, out_valid=0, out_data=0, out_id=0; rinc SHALL be 0 throughout reset.
REQ-029 Reset asserted mid-burst SHALL discard the grant and any undelivered out_data word; popped words are not re-read.

Verification
REQ-030 Reset, then req=4'b0001, rempty=0, out_ready=1, rdata incrementing 0x10.. -> gnt=0001 one cycle later, rinc high 4 consecutive cycles, out_data 0x10..0x13 with out_id=0, then gnt=0 for 1 cycle, then regrant to 0.
REQ-031 req=4'b1111 held, FIFO never empty -> grants cycle 0001,0010,0100,1000,0001, each 4 pops, one IDLE cycle between.
REQ-032 Owner 2 granted, rempty=1 for 5 cycles mid-burst after 2 pops -> rinc=0 and gnt held for those 5 cycles, remaining 2 pops follow, then release.
REQ-033 out_ready=0 with out_valid=1 -> rinc=0 and out_data stable; out_ready returns to 1 -> pop resumes the same cycle.
REQ-034 Owner 1 drops req after 1 pop -> gnt=0 next edge, count discarded, next grant to requester 2 if requesting.
REQ-035 rrst pulsed mid-burst with out_valid=1 -> next cycle gnt=0, out_valid=0, rinc=0; subsequent req=4'b1000 granted to requester 0 first only if req[0]=1, else to 3.
